// File: rtl/lookup_pkg.sv
// Shared definitions for one level of the pipelined range-lookup tree:
// node word field helpers, the update FSM state type and the stat counter width.
package lookup_pkg;

    localparam int STAT_W = 32;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    typedef enum logic [1:0] {
        UPD_IDLE  = 2'd0,
        UPD_WRITE = 2'd1,
        UPD_DONE  = 2'd2
    } upd_state_e;

    // Node word layout, MSB first: {node_valid, pivot[KEY], result[RES]}.
    function automatic int res_width(input int data_w, input int key_w);
        return data_w - 1 - key_w;
    endfunction

    function automatic int node_valid_bit(input int data_w);
        return data_w - 1;
    endfunction

    function automatic int pivot_lsb(input int data_w, input int key_w);
        return res_width(data_w, key_w);
    endfunction

endpackage

// File: rtl/bram_tdp.sv
// Common-clock true dual-port node memory with registered, read-first outputs.
// A read that hits an address being written in the same cycle returns the old word.
module bram_tdp #(
    parameter int    DATA      = 72,
    parameter int    ADDR      = 10,
    parameter string INIT_FILE = "",
    parameter int    STAGE_ID  = 0
) (
    input  logic            clk,
    input  logic            a_wr,
    input  logic [ADDR-1:0] a_addr,
    input  logic [DATA-1:0] a_din,
    output logic [DATA-1:0] a_dout,
    input  logic            b_wr,
    input  logic [ADDR-1:0] b_addr,
    input  logic [DATA-1:0] b_din,
    output logic [DATA-1:0] b_dout
);

    logic [DATA-1:0] mem_q [0:(1<<ADDR)-1];
    logic [DATA-1:0] a_dout_q;
    logic [DATA-1:0] b_dout_q;

    // Both ports share one clock; port B wins if both write the same word.
    always_ff @(posedge clk) begin
        if (a_wr) begin
            mem_q[a_addr] <= a_din;
        end
        if (b_wr) begin
            mem_q[b_addr] <= b_din;
        end
        a_dout_q <= mem_q[a_addr];
        b_dout_q <= mem_q[b_addr];
    end

    assign a_dout = a_dout_q;
    assign b_dout = b_dout_q;

endmodule

// File: rtl/lookup_stage.sv
// One level of the range-lookup tree: reads the addressed node on port A,
// compares the key with the node pivot and hands the child address on.
// Port B is owned by a small update FSM so node rewrites never stall lookups.
//
// Update FSM states:
//   state      | meaning
//   UPD_IDLE   | ready for a node write request (upd_ready=1)
//   UPD_WRITE  | latched word driven onto port B this cycle
//   UPD_DONE   | write committed, upd_done pulses
module lookup_stage
    import lookup_pkg::*;
#(
    parameter int    STAGE_ID         = 0,
    parameter int    KEY              = 32,
    parameter int    DATA             = 72,
    parameter int    ADDR             = 10,
    parameter string MEMINIT_FILENAME = "stage00.mem"
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [KEY-1:0]                    in_key,
    input  logic [ADDR-1:0]                   in_addr,
    input  logic                              in_hit,
    input  logic [res_width(DATA, KEY)-1:0]   in_result,
    output logic                              out_valid,
    output logic [KEY-1:0]                    out_key,
    output logic [ADDR:0]                     out_addr,
    output logic                              out_hit,
    output logic [res_width(DATA, KEY)-1:0]   out_result,
    input  logic                              upd_valid,
    output logic                              upd_ready,
    input  logic [ADDR-1:0]                   upd_addr,
    input  logic [DATA-1:0]                   upd_data,
    output logic                              upd_done,
    output logic [STAT_W-1:0]                 stat_hits
);

    localparam int RES  = res_width(DATA, KEY);
    localparam int VBIT = node_valid_bit(DATA);
    localparam int PLSB = pivot_lsb(DATA, KEY);

    logic [DATA-1:0]   a_rdata;
    logic [DATA-1:0]   unused_b_rdata;

    logic              s1_valid_q;
    logic [KEY-1:0]    s1_key_q;
    logic [ADDR-1:0]   s1_addr_q;
    logic              s1_hit_q;
    logic [RES-1:0]    s1_result_q;

    logic              out_valid_q;
    logic [KEY-1:0]    out_key_q;
    logic [ADDR:0]     out_addr_q;
    logic              out_hit_q;
    logic [RES-1:0]    out_result_q;
    logic [STAT_W-1:0] stat_q;
    logic [STAT_W-1:0] stat_d;

    upd_state_e        state_q;
    logic              upd_ready_q;
    logic              upd_done_q;
    logic              b_wr_q;
    logic [ADDR-1:0]   b_addr_q;
    logic [DATA-1:0]   b_data_q;

    logic              node_valid;
    logic [KEY-1:0]    node_pivot;
    logic [RES-1:0]    node_result;
    logic              taken;

    bram_tdp #(
        .DATA      (DATA),
        .ADDR      (ADDR),
        .INIT_FILE (MEMINIT_FILENAME),
        .STAGE_ID  (STAGE_ID)
    ) u_mem (
        .clk    (clk),
        .a_wr   (1'b0),
        .a_addr (in_addr),
        .a_din  ('0),
        .a_dout (a_rdata),
        .b_wr   (b_wr_q),
        .b_addr (b_addr_q),
        .b_din  (b_data_q),
        .b_dout (unused_b_rdata)
    );

    assign node_valid  = a_rdata[VBIT];
    assign node_pivot  = a_rdata[PLSB +: KEY];
    assign node_result = a_rdata[RES-1:0];
    assign taken       = node_valid && (s1_key_q >= node_pivot);

    assign stat_d = (s1_valid_q && taken && (stat_q != STAT_MAX)) ? stat_q + STAT_W'(1) : stat_q;

    // Delay the token one cycle so it lines up with the registered node word.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_key_q    <= '0;
            s1_addr_q   <= '0;
            s1_hit_q    <= 1'b0;
            s1_result_q <= '0;
        end else begin
            s1_valid_q  <= in_valid;
            s1_key_q    <= in_key;
            s1_addr_q   <= in_addr;
            s1_hit_q    <= in_hit;
            s1_result_q <= in_result;
        end
    end

    // Register the compare outcome and the hit statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_key_q    <= '0;
            out_addr_q   <= '0;
            out_hit_q    <= 1'b0;
            out_result_q <= '0;
            stat_q       <= '0;
        end else begin
            out_valid_q  <= s1_valid_q;
            out_key_q    <= s1_key_q;
            out_addr_q   <= {s1_addr_q, taken};
            out_hit_q    <= s1_hit_q | taken;
            out_result_q <= taken ? node_result : s1_result_q;
            stat_q       <= stat_d;
        end
    end

    // Update FSM; a write already on port B at a reset edge still lands in memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= UPD_IDLE;
            upd_ready_q <= 1'b0;
            upd_done_q  <= 1'b0;
            b_wr_q      <= 1'b0;
        end else begin
            case (state_q)
                UPD_IDLE: begin
                    upd_done_q <= 1'b0;
                    if (upd_valid && upd_ready_q) begin
                        state_q     <= UPD_WRITE;
                        upd_ready_q <= 1'b0;
                        b_wr_q      <= 1'b1;
                        b_addr_q    <= upd_addr;
                        b_data_q    <= upd_data;
                    end else begin
                        upd_ready_q <= 1'b1;
                    end
                end
                UPD_WRITE: begin
                    state_q    <= UPD_DONE;
                    b_wr_q     <= 1'b0;
                    upd_done_q <= 1'b1;
                end
                UPD_DONE: begin
                    state_q     <= UPD_IDLE;
                    upd_done_q  <= 1'b0;
                    upd_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= UPD_IDLE;
                    upd_ready_q <= 1'b0;
                    upd_done_q  <= 1'b0;
                    b_wr_q      <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_key    = out_key_q;
    assign out_addr   = out_addr_q;
    assign out_hit    = out_hit_q;
    assign out_result = out_result_q;
    assign upd_ready  = upd_ready_q;
    assign upd_done   = upd_done_q;
    assign stat_hits  = stat_q;

endmodule

// File: tb/tb_lookup_stage.sv
// Randomized scoreboard bench for lookup_stage with a behavioural node-memory model.
module tb_lookup_stage;

    localparam int KEY  = 32;
    localparam int DATA = 72;
    localparam int ADDR = 10;
    localparam int RES  = DATA - 1 - KEY;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [KEY-1:0]  in_key;
    logic [ADDR-1:0] in_addr;
    logic            in_hit;
    logic [RES-1:0]  in_result;
    logic            out_valid;
    logic [KEY-1:0]  out_key;
    logic [ADDR:0]   out_addr;
    logic            out_hit;
    logic [RES-1:0]  out_result;
    logic            upd_valid;
    logic            upd_ready;
    logic [ADDR-1:0] upd_addr;
    logic [DATA-1:0] upd_data;
    logic            upd_done;
    logic [31:0]     stat_hits;

    always #5 clk = ~clk;

    lookup_stage #(
        .STAGE_ID         (0),
        .KEY              (KEY),
        .DATA             (DATA),
        .ADDR             (ADDR),
        .MEMINIT_FILENAME ("stage00.mem")
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_key     (in_key),
        .in_addr    (in_addr),
        .in_hit     (in_hit),
        .in_result  (in_result),
        .out_valid  (out_valid),
        .out_key    (out_key),
        .out_addr   (out_addr),
        .out_hit    (out_hit),
        .out_result (out_result),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_addr   (upd_addr),
        .upd_data   (upd_data),
        .upd_done   (upd_done),
        .stat_hits  (stat_hits)
    );

    typedef struct {
        int              due;
        logic [KEY-1:0]  key;
        logic [ADDR:0]   addr;
        logic            hit;
        logic [RES-1:0]  res;
        logic [31:0]     stat;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            me;
    logic [DATA-1:0] mirror [0:(1<<ADDR)-1];
    logic [ADDR-1:0] pool [16];
    int              cyc = 0;
    int              n_checks = 0;
    int              n_fail = 0;
    // Update side model: 0 idle, 1 writing, 2 done pulse, 3 just reset.
    int              ph = 3;
    logic [ADDR-1:0] pend_a;
    logic [DATA-1:0] pend_d;
    logic [31:0]     stat_model = 0;

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    function automatic logic [RES-1:0] rand_res();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[RES-1:0];
    endfunction

    function automatic logic [DATA-1:0] rand_node();
        logic            v;
        logic [KEY-1:0]  p;
        v = ($urandom_range(3) != 0);
        p = $urandom;
        return {v, p, rand_res()};
    endfunction

    // Expected outcome of a token, from the node rules applied to the model memory.
    function automatic exp_t predict(input logic [KEY-1:0] k, input logic [ADDR-1:0] a,
                                     input logic h, input logic [RES-1:0] r);
        exp_t            e;
        logic [DATA-1:0] node;
        logic            nv;
        logic [KEY-1:0]  piv;
        logic [RES-1:0]  nres;
        bit              take;
        node = mirror[a];
        nv   = node[DATA-1];
        piv  = node[DATA-2 -: KEY];
        nres = node[RES-1:0];
        take = nv && (k >= piv);
        if (take && stat_model != 32'hFFFF_FFFF) stat_model = stat_model + 1;
        e.due  = cyc + 2;
        e.key  = k;
        e.addr = {a, take};
        e.hit  = h | take;
        e.res  = take ? nres : r;
        e.stat = stat_model;
        return e;
    endfunction

    // One clock cycle of stimulus plus model bookkeeping.
    task automatic step(input bit tv, input logic [KEY-1:0] k, input logic [ADDR-1:0] a,
                        input logic h, input logic [RES-1:0] r, input bit uv,
                        input logic [ADDR-1:0] ua, input logic [DATA-1:0] ud, input bit rs);
        bit accepted;
        chk("upd_ready", upd_ready, (ph == 0));
        chk("upd_done", upd_done, (ph == 2));
        in_valid  = tv;
        in_key    = k;
        in_addr   = a;
        in_hit    = h;
        in_result = r;
        upd_valid = uv;
        upd_addr  = ua;
        upd_data  = ud;
        rst       = rs;
        if (tv && !rs) exp_q.push_back(predict(k, a, h, r));
        if (rs) begin
            while (exp_q.size() != 0 && exp_q[exp_q.size()-1].due >= cyc + 1) exp_q.pop_back();
            stat_model = 0;
        end
        accepted = uv && (ph == 0) && !rs;
        @(posedge clk);
        cyc++;
        #2;
        if (rs) begin
            if (ph == 1) mirror[pend_a] = pend_d;
            ph = 3;
        end else begin
            case (ph)
                0: if (accepted) begin
                    ph = 1;
                    pend_a = ua;
                    pend_d = ud;
                end
                1: begin
                    mirror[pend_a] = pend_d;
                    ph = 2;
                end
                default: ph = 0;
            endcase
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, 0, '0, '0, 0);
    endtask

    task automatic tok(input logic [KEY-1:0] k, input logic [ADDR-1:0] a,
                       input logic h, input logic [RES-1:0] r);
        step(1, k, a, h, r, 0, '0, '0, 0);
    endtask

    // Holds the request until the model says it is accepted.
    task automatic wr(input logic [ADDR-1:0] ua, input logic [DATA-1:0] ud);
        bit acc;
        for (int t = 0; t < 8; t++) begin
            acc = (ph == 0);
            step(0, '0, '0, 0, '0, 1, ua, ud, 0);
            if (acc) break;
        end
    endtask

    // Scoreboard monitor: one expectation consumed per presented token.
    always @(negedge clk) begin
        chk("out_valid", out_valid, (exp_q.size() != 0) && (exp_q[0].due <= cyc));
        if (out_valid === 1'b1 && exp_q.size() != 0) begin
            me = exp_q.pop_front();
            chk("latency", cyc, me.due);
            chk("out_key", out_key, me.key);
            chk("out_addr", out_addr, me.addr);
            chk("out_hit", out_hit, me.hit);
            chk("out_result", out_result, me.res);
            chk("stat_hits", stat_hits, me.stat);
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            me = exp_q.pop_front();
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR-1:0] ra;
        logic [KEY-1:0]  rk;
        logic [KEY-1:0]  piv;
        logic [DATA-1:0] nw;
        bit              tv;
        bit              rs;
        bit              req;
        bit              acc;
        int              rst_left;
        logic [ADDR-1:0] req_a;
        logic [DATA-1:0] req_d;

        rst = 1'b1;
        in_valid = 0; in_key = '0; in_addr = '0; in_hit = 0; in_result = '0;
        upd_valid = 0; upd_addr = '0; upd_data = '0;
        for (int i = 0; i < (1 << ADDR); i++) mirror[i] = '0;
        for (int i = 0; i < 14; i++) pool[i] = ADDR'(i);
        pool[14] = 10'd512;
        pool[15] = 10'd1023;

        repeat (3) begin
            @(posedge clk);
            cyc++;
        end
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_key", out_key, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_hit", out_hit, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_upd_done", upd_done, 0);
        chk("rst_upd_ready", upd_ready, 0);
        chk("rst_stat_hits", stat_hits, 0);
        idle(1);

        for (int i = 0; i < 16; i++) wr(pool[i], rand_node());
        idle(2);

        // Directed: pivot boundary, hit passthrough, invalid node.
        wr(10'd5, {1'b1, 32'h0000_1000, 39'h12});
        idle(2);
        wr(10'd6, '0);
        idle(2);
        tok(32'h0000_1000, 10'd5, 1'b0, '0);
        tok(32'h0000_0FFF, 10'd5, 1'b1, 39'h7);
        tok($urandom, 10'd6, 1'b0, 39'h55);
        idle(3);

        // Back-to-back tokens to alternating nodes.
        for (int i = 0; i < 8; i++) tok(32'h0000_0FFE + i, (i % 2 == 0) ? 10'd5 : 10'd6, i[1], RES'(i));
        idle(3);

        // Write/read collision on node 5.
        wr(10'd5, {1'b1, 32'h0000_2000, 39'h34});
        tok(32'h0000_1800, 10'd5, 1'b0, '0);
        tok(32'h0000_1800, 10'd5, 1'b0, '0);
        idle(3);

        // Reset with two tokens in flight and a write on port B.
        wr(10'd7, {1'b1, 32'h0000_0100, 39'h77});
        idle(2);
        step(1, 32'h60, 10'd7, 0, '0, 1, 10'd7, {1'b1, 32'h0000_0050, 39'h66}, 0);
        step(1, 32'h60, 10'd7, 0, '0, 0, '0, '0, 1);
        step(0, '0, '0, 0, '0, 0, '0, '0, 1);
        chk("reset_stat_hits", stat_hits, 0);
        idle(2);
        tok(32'h0000_0060, 10'd7, 1'b0, '0);
        tok(32'h0000_0040, 10'd7, 1'b0, 39'h3);
        idle(3);

        // Randomized traffic with concurrent updates and occasional resets.
        req = 0;
        rst_left = 0;
        req_a = '0;
        req_d = '0;
        for (int i = 0; i < 2000; i++) begin
            tv  = ($urandom_range(9) < 7);
            ra  = pool[$urandom_range(15)];
            nw  = mirror[ra];
            piv = nw[DATA-2 -: KEY];
            case ($urandom_range(3))
                0: rk = piv;
                1: rk = piv - 1;
                2: rk = piv + 1;
                default: rk = $urandom;
            endcase
            if (!req && $urandom_range(7) == 0) begin
                req   = 1;
                req_a = pool[$urandom_range(15)];
                req_d = rand_node();
            end
            if (rst_left > 0) begin
                rs = 1;
                rst_left--;
            end else if ($urandom_range(499) == 0) begin
                rs = 1;
                rst_left = $urandom_range(1);
            end else begin
                rs = 0;
            end
            acc = req && (ph == 0) && !rs;
            step(tv, rk, ra, 1'($urandom_range(1)), rand_res(), req, req_a, req_d, rs);
            if (acc) req = 0;
        end
        idle(6);
        chk("drain_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
